// File: rtl/fp_pkg.sv
// Shared types and constants for the fp32 div/sqrt result packer.
package fp_pkg;

    localparam int          BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } pack_state_t;

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x.exp == 8'h00);
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == 23'd0);
    endfunction

    function automatic logic fp_is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != 23'd0);
    endfunction

endpackage

// File: rtl/fp_special_case.sv
// Combinational classification of the latched operands: decides whether the
// operation bypasses the mantissa datapath and, if so, what it returns.
module fp_special_case
    import fp_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_op,
    output logic        o_is_special,
    output logic [31:0] o_special_result,
    output flags_t      o_special_flags
);

    fp32_t w_a;
    fp32_t w_b;
    logic  w_a_zero, w_a_inf, w_a_nan;
    logic  w_b_zero, w_b_inf, w_b_nan;
    logic  w_div_sign;

    assign w_a        = i_a;
    assign w_b        = i_b;
    assign w_a_zero   = fp_is_zero(w_a);
    assign w_a_inf    = fp_is_inf(w_a);
    assign w_a_nan    = fp_is_nan(w_a);
    assign w_b_zero   = fp_is_zero(w_b);
    assign w_b_inf    = fp_is_inf(w_b);
    assign w_b_nan    = fp_is_nan(w_b);
    assign w_div_sign = w_a.sign ^ w_b.sign;

    // Priority-ordered special-case resolution; falls through to ordinary.
    always_comb begin
        o_is_special     = 1'b1;
        o_special_result = 32'd0;
        o_special_flags  = '0;
        if (i_op == 2'b00) begin
            if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                o_special_result        = QNAN;
                o_special_flags.invalid = 1'b1;
            end else if (w_a_inf) begin
                o_special_result = {w_div_sign, 8'hFF, 23'd0};
            end else if (w_b_zero) begin
                o_special_result            = {w_div_sign, 8'hFF, 23'd0};
                o_special_flags.div_by_zero = 1'b1;
            end else if (w_b_inf || w_a_zero) begin
                o_special_result = {w_div_sign, 31'd0};
            end else begin
                o_is_special = 1'b0;
            end
        end else begin
            if (w_a_nan || (w_a.sign && !w_a_zero)) begin
                o_special_result        = QNAN;
                o_special_flags.invalid = 1'b1;
            end else if (w_a_zero) begin
                o_special_result = {w_a.sign, 31'd0};
            end else if (w_a_inf) begin
                o_special_result = 32'h7F80_0000;
            end else begin
                o_is_special = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_result_pack.sv
// Sequencer/packer behind the Goldschmidt mantissa stage: latches an op,
// pulses mant_reset, waits the stage latency, then builds the fp32 result.
// Optional feature macro: FP_RESULT_PACK_STICKY_FLAGS_EN (sticky flag register).
module fp_result_pack
    import fp_pkg::*;
#(
    parameter int DIV_LAT  = 10,
    parameter int SQRT_LAT = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        round_mode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        mant_reset,
    input  logic [22:0] m3,
    input  logic        dec_exp,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FP_RESULT_PACK_STICKY_FLAGS_EN
    ,
    input  logic        flag_clear,
    output logic [3:0]  sticky_flags
`endif
);

    localparam int                 CNT_W    = 5;
    localparam logic signed [9:0]  EXP_BIAS = 10'(BIAS);

    pack_state_t       r_state, w_state_next;
    logic [1:0]        r_op;
    logic              r_rz;
    fp32_t             r_a, r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_result;
    flags_t            r_flags;

    logic              w_is_special;
    logic [31:0]       w_special_result;
    flags_t            w_special_flags;

    logic              w_div, w_sign, w_cnt_done;
    logic signed [9:0] w_ea, w_eb, w_ea_unb, w_half, w_exp_base, w_exp;
    logic [31:0]       w_pack_result;
    flags_t            w_pack_flags;

    fp_special_case u_special (
        .i_a              (r_a),
        .i_b              (r_b),
        .i_op             (r_op),
        .o_is_special     (w_is_special),
        .o_special_result (w_special_result),
        .o_special_flags  (w_special_flags)
    );

    assign in_ready   = (r_state == IDLE);
    assign mant_reset = (r_state == KICK);
    assign out_valid  = (r_state == DONE);
    assign result     = r_result;
    assign flags      = r_flags;
    assign w_cnt_done = (r_cnt == '0);

    // Exponent in 10-bit signed arithmetic; sqrt halves the unbiased exponent
    // with an arithmetic shift so odd negative exponents round toward -inf.
    assign w_div      = (r_op == 2'b00);
    assign w_sign     = w_div ? (r_a.sign ^ r_b.sign) : r_a.sign;
    assign w_ea       = {2'b00, r_a.exp};
    assign w_eb       = {2'b00, r_b.exp};
    assign w_ea_unb   = w_ea - EXP_BIAS;
    assign w_half     = w_ea_unb >>> 1;
    assign w_exp_base = w_div ? (w_ea - w_eb + EXP_BIAS) : (w_half + EXP_BIAS);
    assign w_exp      = w_exp_base - $signed({9'd0, dec_exp});

    // Pack the ordinary result, saturating on overflow and flushing on underflow.
    always_comb begin
        w_pack_result = {w_sign, w_exp[7:0], m3};
        w_pack_flags  = '0;
        if (w_exp >= 10'sd255) begin
            w_pack_flags.overflow = 1'b1;
            w_pack_result         = r_rz ? {w_sign, 31'h7F7F_FFFF} : {w_sign, 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_pack_flags.underflow = 1'b1;
            w_pack_result          = {w_sign, 31'd0};
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = KICK;
            KICK:    w_state_next = w_is_special ? DONE : BUSY;
            BUSY:    if (w_cnt_done) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Operand latch, latency counter and result registers. The counter is
    // loaded on accept and runs through KICK so it hits zero on the edge
    // where the mantissa stage presents m3.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_rz     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_rz  <= round_mode;
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= (op == 2'b00) ? CNT_W'(DIV_LAT) : CNT_W'(SQRT_LAT);
                    end
                end
                KICK: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_is_special) begin
                        r_result <= w_special_result;
                        r_flags  <= w_special_flags;
                    end
                end
                BUSY: begin
                    if (w_cnt_done) begin
                        r_result <= w_pack_result;
                        r_flags  <= w_pack_flags;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP_RESULT_PACK_STICKY_FLAGS_EN
    flags_t r_sticky;

    // Accumulate flags on each handshake; a clear on the same cycle loses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= '0;
        end else if (out_valid && out_ready) begin
            r_sticky <= r_sticky | r_flags;
        end else if (flag_clear) begin
            r_sticky <= '0;
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fp_result_pack.sv
// Scoreboard bench for fp_result_pack: stimulus pushes model results, a
// negedge monitor pops and compares on each handshake. Also models the
// mantissa stage by presenting m3/dec_exp only on the cycle it is valid.
// Optional feature macro: FP_RESULT_PACK_STICKY_FLAGS_EN (ports tied off here).
module tb_fp_result_pack;

    localparam int DIV_LAT  = 10;
    localparam int SQRT_LAT = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        round_mode = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [22:0] m3 = 23'd0;
    logic        dec_exp = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, mant_reset, out_valid;
    logic [31:0] result;
    logic [3:0]  flags;
`ifdef FP_RESULT_PACK_STICKY_FLAGS_EN
    logic        flag_clear = 1'b0;
    logic [3:0]  sticky_flags;
`endif

    fp_result_pack #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_ready   (in_ready),
        .op         (op),
        .round_mode (round_mode),
        .a          (a),
        .b          (b),
        .mant_reset (mant_reset),
        .m3         (m3),
        .dec_exp    (dec_exp),
        .result     (result),
        .flags      (flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FP_RESULT_PACK_STICKY_FLAGS_EN
        ,
        .flag_clear   (flag_clear),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Reference: IEEE-style special cases with FTZ, then exponent arithmetic on ints.
    function automatic void model(input logic [1:0] o, input logic rz, input logic [31:0] av,
                                  input logic [31:0] bv, input logic [22:0] mv, input logic dv,
                                  output logic [31:0] res, output logic [3:0] flg, output bit sp);
        int ea = int'(av[30:23]);
        int eb = int'(bv[30:23]);
        bit sa = av[31];
        bit sb = bv[31];
        bit za = (ea == 0);
        bit zb = (eb == 0);
        bit ia = (ea == 255) && (av[22:0] == 0);
        bit ib = (eb == 255) && (bv[22:0] == 0);
        bit na = (ea == 255) && (av[22:0] != 0);
        bit nb = (eb == 255) && (bv[22:0] != 0);
        bit sg;
        int e = 0;
        int t;
        flg = 4'b0000;
        res = 32'd0;
        sp  = 1'b1;
        if (o == 2'd0) begin
            sg = sa ^ sb;
            if (na || nb || (za && zb) || (ia && ib)) begin res = 32'h7FC00000; flg = 4'b1000; end
            else if (ia) res = {sg, 8'hFF, 23'd0};
            else if (zb) begin res = {sg, 8'hFF, 23'd0}; flg = 4'b0100; end
            else if (ib || za) res = {sg, 31'd0};
            else begin sp = 1'b0; e = ea - eb + 127 - int'(dv); end
        end else begin
            sg = sa;
            if (na || (sa && !za)) begin res = 32'h7FC00000; flg = 4'b1000; end
            else if (za) res = {sa, 31'd0};
            else if (ia) res = 32'h7F800000;
            else begin
                sp = 1'b0;
                t  = ea - 127;
                e  = ((t < 0) ? -((1 - t) / 2) : (t / 2)) + 127 - int'(dv);
            end
        end
        if (!sp) begin
            if (e >= 255) begin
                flg = 4'b0010;
                res = rz ? {sg, 31'h7F7FFFFF} : {sg, 8'hFF, 23'd0};
            end else if (e <= 0) begin
                flg = 4'b0001;
                res = {sg, 31'd0};
            end else begin
                res = {sg, e[7:0], mv};
            end
        end
    endfunction

    // Monitor: latency on first valid, stability while stalled, compare on handshake.
    initial begin
        bit          seen = 1'b0;
        logic [31:0] held_res = 32'd0;
        logic [3:0]  held_flg = 4'd0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (mon_en && out_valid) begin
                chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    seen     = 1'b1;
                    held_res = result;
                    held_flg = flags;
                    if (sb_q.size() == 0) fail_now("unexpected_out_valid");
                    else chk("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
                end else begin
                    chk("result_stable", result, held_res);
                    chk("flags_stable", {28'd0, flags}, {28'd0, held_flg});
                end
                if (out_ready) begin
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("result", result, e.res);
                        chk("flags", {28'd0, flags}, {28'd0, e.flg});
                        $display("txn %0d: result=%h flags=%b exp_result=%h exp_flags=%b",
                                 txn, result, flags, e.res, e.flg);
                        txn++;
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    // Issue one operation; called and returning at a negedge.
    task automatic run_op(input logic [1:0] o, input logic rz, input logic [31:0] av,
                          input logic [31:0] bv, input logic [22:0] mv, input logic dv,
                          input bit bp);
        logic [31:0] er;
        logic [3:0]  ef;
        bit          sp;
        int          n;
        int          lat;
        model(o, rz, av, bv, mv, dv, er, ef, sp);
        lat = (o == 2'd0) ? DIV_LAT : SQRT_LAT;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) fail_now("in_ready_timeout");
        op = o; round_mode = rz; a = av; b = bv; start = 1'b1; out_ready = !bp;
        @(posedge clk);
        #1;
        sb_q.push_back('{er, ef, sp ? 2 : lat + 2, cyc});
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom); round_mode = 1'($urandom);
        @(negedge clk);
        chk("mant_reset_pulse", {31'd0, mant_reset}, 32'd1);
        if (!sp) begin
            repeat (lat) @(posedge clk);
            #1 m3 = mv; dec_exp = dv;
            @(posedge clk);
            #1 m3 = 23'($urandom); dec_exp = 1'($urandom);
        end
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) fail_now("out_valid_timeout");
        if (bp) begin
            repeat (5) begin @(posedge clk); #1 start = 1'b1; a = $urandom; end
            @(posedge clk);
            #1 start = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("idle_after_handshake", {31'd0, in_ready}, 32'd1);
        chk("no_kick_after_handshake", {31'd0, mant_reset}, 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_fp(input bit pos);
        logic [7:0] ex;
        int         r = int'($urandom_range(0, 9));
        if (r == 0)      ex = 8'h00;
        else if (r == 1) ex = 8'hFF;
        else             ex = 8'($urandom_range(1, 254));
        return {pos ? 1'b0 : 1'($urandom), ex, (ex == 8'hFF && $urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ro;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mant_reset", {31'd0, mant_reset}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        run_op(2'd0, 1'b0, 32'h40C00000, 32'h40000000, 23'h400000, 1'b0, 1'b0);
        run_op(2'd1, 1'b0, 32'h40800000, 32'hDEADBEEF, 23'h000000, 1'b0, 1'b0);
        run_op(2'd0, 1'b0, 32'h3F800000, 32'h00000000, 23'h123456, 1'b1, 1'b0);
        run_op(2'd0, 1'b0, 32'h7F000000, 32'h00800000, 23'h000000, 1'b0, 1'b0);
        run_op(2'd0, 1'b1, 32'h7F000000, 32'h00800000, 23'h000000, 1'b0, 1'b1);
        run_op(2'd1, 1'b0, 32'hBF800000, 32'h00000000, 23'h000000, 1'b0, 1'b0);
        run_op(2'd0, 1'b0, 32'h80800000, 32'h7F000000, 23'h2AAAAA, 1'b0, 1'b0);
        run_op(2'd3, 1'b1, 32'h3E800000, 32'h00000000, 23'h000000, 1'b1, 1'b1);

        // Abort mid-BUSY with reset: no output, idle immediately, result cleared.
        op = 2'd0; a = 32'h40C00000; b = 32'h40000000; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_mant_reset", {31'd0, mant_reset}, 32'd0);
        chk("abort_result", result, 32'd0);
        out_ready = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            run_op(ro, 1'($urandom), rand_fp((ro != 2'd0) && ($urandom_range(0, 3) != 0)),
                   rand_fp(1'b0), 23'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
